// File: rtl/dpa_dbpsk_symbol_slicer.sv
// DBPSK symbol slicer: carrier squelch FSM, integrate-and-dump, hard decision.
// Optional macro DPA_SLICER_SATURATE_EN: sticky saturating accumulation.
module dpa_dbpsk_symbol_slicer #(
    parameter int IN_W         = 32,
    parameter int ACC_W        = 40,
    parameter int SPS          = 16,
    parameter int LOCK_COUNT   = 8,
    parameter int UNLOCK_COUNT = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clk_enable,
    input  logic [127:0]            addition_in,
    input  logic [95:0]             subtraction_in,
    input  logic [IN_W-1:0]         energy_threshold,
    output logic                    ce_out,
    output logic                    carrier_lock,
    output logic                    bit_valid,
    output logic                    bit_out,
    output logic signed [ACC_W-1:0] soft_out,
    output logic signed [ACC_W-1:0] freq_err
);

    localparam int SC_W = (SPS > 1) ? $clog2(SPS) : 1;
    localparam int HC_W = $clog2(LOCK_COUNT + 1);
    localparam int MC_W = $clog2(UNLOCK_COUNT + 1);

    localparam logic [IN_W-1:0] MAG_MAX = {1'b0, {(IN_W-1){1'b1}}};
    localparam logic [IN_W-1:0] NEG_MIN = {1'b1, {(IN_W-1){1'b0}}};

    typedef enum logic {
        SEARCH,
        TRACK
    } state_t;

    state_t state_q, state_d;

    logic [SC_W-1:0] samp_cnt_q, samp_cnt_d;
    logic [HC_W-1:0] hit_cnt_q, hit_cnt_d;
    logic [MC_W-1:0] miss_cnt_q, miss_cnt_d;

    logic signed [ACC_W-1:0] acc_add_q, acc_add_d;
    logic signed [ACC_W-1:0] acc_sub_q, acc_sub_d;
    logic signed [ACC_W-1:0] soft_q, soft_d;
    logic signed [ACC_W-1:0] ferr_q, ferr_d;
    logic                    bit_q, bit_d;
    logic                    bv_q, bv_d;

    logic [IN_W-1:0]         add_u, sub_u;
    logic signed [IN_W-1:0]  add_s, sub_s;
    logic signed [ACC_W-1:0] add_x, sub_x;
    logic [IN_W-1:0]         mag;
    logic                    hit;
    logic signed [ACC_W-1:0] sum_add, sum_sub;

    // Only the top IN_W bits of each demodulator word carry the signal.
    logic unused_low_bits;
    assign unused_low_bits = ^{addition_in[127-IN_W:0],
                               subtraction_in[95-IN_W:0]};

    assign add_u = addition_in[127 -: IN_W];
    assign sub_u = subtraction_in[95 -: IN_W];
    assign add_s = signed'(add_u);
    assign sub_s = signed'(sub_u);
    assign add_x = ACC_W'(add_s);
    assign sub_x = ACC_W'(sub_s);

    // Magnitude with the most negative code folded onto the largest positive.
    assign mag = !add_u[IN_W-1] ? add_u :
                 (add_u == NEG_MIN) ? MAG_MAX : IN_W'(-add_s);
    assign hit = mag > energy_threshold;

`ifdef DPA_SLICER_SATURATE_EN
    logic [1:0] stk_q, stk_d, stk_nxt;

    // Returns {clamped, value}; once clamped the accumulator is frozen.
    function automatic logic [ACC_W:0] sat_add(
        input logic signed [ACC_W-1:0] acc,
        input logic signed [ACC_W-1:0] x,
        input logic                    stk
    );
        logic [ACC_W:0] w;
        w = {acc[ACC_W-1], acc} + {x[ACC_W-1], x};
        if (stk)
            return {1'b1, acc};
        if (w[ACC_W] ^ w[ACC_W-1])
            return {1'b1, w[ACC_W], {(ACC_W-1){~w[ACC_W]}}};
        return {1'b0, w[ACC_W-1:0]};
    endfunction

    assign {stk_nxt[0], sum_add} = sat_add(acc_add_q, add_x, stk_q[0]);
    assign {stk_nxt[1], sum_sub} = sat_add(acc_sub_q, sub_x, stk_q[1]);
`else
    assign sum_add = acc_add_q + add_x;
    assign sum_sub = acc_sub_q + sub_x;
`endif

    // Lock FSM, symbol integration and dump decision.
    always_comb begin
        state_d    = state_q;
        samp_cnt_d = samp_cnt_q;
        hit_cnt_d  = hit_cnt_q;
        miss_cnt_d = miss_cnt_q;
        acc_add_d  = acc_add_q;
        acc_sub_d  = acc_sub_q;
        soft_d     = soft_q;
        ferr_d     = ferr_q;
        bit_d      = bit_q;
        bv_d       = 1'b0;
`ifdef DPA_SLICER_SATURATE_EN
        stk_d      = stk_q;
`endif
        if (clk_enable) begin
            unique case (state_q)
                SEARCH: begin
                    if (!hit) begin
                        hit_cnt_d = '0;
                    end else if (hit_cnt_q == HC_W'(LOCK_COUNT - 1)) begin
                        state_d    = TRACK;
                        hit_cnt_d  = HC_W'(LOCK_COUNT);
                        miss_cnt_d = '0;
                        samp_cnt_d = '0;
                        acc_add_d  = '0;
                        acc_sub_d  = '0;
`ifdef DPA_SLICER_SATURATE_EN
                        stk_d      = '0;
`endif
                    end else begin
                        hit_cnt_d = hit_cnt_q + 1'b1;
                    end
                end
                TRACK: begin
                    if (!hit && miss_cnt_q == MC_W'(UNLOCK_COUNT - 1)) begin
                        // Unlock takes priority over a coincident dump.
                        state_d    = SEARCH;
                        miss_cnt_d = MC_W'(UNLOCK_COUNT);
                        hit_cnt_d  = '0;
                        samp_cnt_d = '0;
                        acc_add_d  = '0;
                        acc_sub_d  = '0;
`ifdef DPA_SLICER_SATURATE_EN
                        stk_d      = '0;
`endif
                    end else begin
                        miss_cnt_d = hit ? '0 : miss_cnt_q + 1'b1;
                        if (samp_cnt_q == SC_W'(SPS - 1)) begin
                            soft_d     = sum_add;
                            ferr_d     = sum_sub;
                            bit_d      = sum_add[ACC_W-1];
                            bv_d       = 1'b1;
                            samp_cnt_d = '0;
                            acc_add_d  = '0;
                            acc_sub_d  = '0;
`ifdef DPA_SLICER_SATURATE_EN
                            stk_d      = '0;
`endif
                        end else begin
                            samp_cnt_d = samp_cnt_q + 1'b1;
                            acc_add_d  = sum_add;
                            acc_sub_d  = sum_sub;
`ifdef DPA_SLICER_SATURATE_EN
                            stk_d      = stk_nxt;
`endif
                        end
                    end
                end
                default: state_d = SEARCH;
            endcase
        end
    end

    // State, counter, accumulator and output registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= SEARCH;
            samp_cnt_q <= '0;
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
            acc_add_q  <= '0;
            acc_sub_q  <= '0;
            soft_q     <= '0;
            ferr_q     <= '0;
            bit_q      <= 1'b0;
            bv_q       <= 1'b0;
`ifdef DPA_SLICER_SATURATE_EN
            stk_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            samp_cnt_q <= samp_cnt_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
            acc_add_q  <= acc_add_d;
            acc_sub_q  <= acc_sub_d;
            soft_q     <= soft_d;
            ferr_q     <= ferr_d;
            bit_q      <= bit_d;
            bv_q       <= bv_d;
`ifdef DPA_SLICER_SATURATE_EN
            stk_q      <= stk_d;
`endif
        end
    end

    assign ce_out       = clk_enable;
    assign carrier_lock = (state_q == TRACK);
    assign bit_valid    = bv_q;
    assign bit_out      = bit_q;
    assign soft_out     = soft_q;
    assign freq_err     = ferr_q;

endmodule

// File: tb/tb_dpa_dbpsk_symbol_slicer.sv
// Bench for dpa_dbpsk_symbol_slicer: directed plan steps plus random traffic,
// checked against a queue-based symbol model.
module tb_dpa_dbpsk_symbol_slicer;

    localparam int ACC_W = 34;

    logic                    clk;
    logic                    reset;
    logic                    clk_enable;
    logic [127:0]            addition_in;
    logic [95:0]             subtraction_in;
    logic [31:0]             energy_threshold;
    logic                    ce_out;
    logic                    carrier_lock;
    logic                    bit_valid;
    logic                    bit_out;
    logic signed [ACC_W-1:0] soft_out;
    logic signed [ACC_W-1:0] freq_err;

    dpa_dbpsk_symbol_slicer #(
        .IN_W(32), .ACC_W(ACC_W), .SPS(16),
        .LOCK_COUNT(8), .UNLOCK_COUNT(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .clk_enable(clk_enable),
        .addition_in(addition_in),
        .subtraction_in(subtraction_in),
        .energy_threshold(energy_threshold),
        .ce_out(ce_out),
        .carrier_lock(carrier_lock),
        .bit_valid(bit_valid),
        .bit_out(bit_out),
        .soft_out(soft_out),
        .freq_err(freq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_err    = 0;
    int bv_seen  = 0;

    // Reference model: lock flag, hit/miss run lengths, samples of the symbol.
    bit                      m_lock;
    int                      m_hits;
    int                      m_miss;
    int                      qa[$];
    int                      qs[$];
    bit                      m_bv;
    bit                      m_bit;
    logic signed [ACC_W-1:0] m_soft;
    logic signed [ACC_W-1:0] m_ferr;

    task automatic chk(input string tag,
                       input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic signed [ACC_W-1:0] msum(input int q[$]);
        longint acc = 0;
        longint hi  = (64'sd1 <<< (ACC_W - 1)) - 1;
        longint lo  = -(64'sd1 <<< (ACC_W - 1));
        bit stuck   = 0;
        foreach (q[i]) begin
            if (!stuck) begin
                acc += longint'(q[i]);
`ifdef DPA_SLICER_SATURATE_EN
                if (acc > hi) begin acc = hi; stuck = 1; end
                else if (acc < lo) begin acc = lo; stuck = 1; end
`endif
            end
        end
        if (hi < lo) acc = 0;
        return acc[ACC_W-1:0];
    endfunction

    task automatic model_reset();
        m_lock = 0; m_hits = 0; m_miss = 0;
        qa.delete(); qs.delete();
        m_bv = 0; m_bit = 0; m_soft = '0; m_ferr = '0;
    endtask

    task automatic model_step(input int a, input int s, input bit ce);
        longint mg;
        bit hit;
        m_bv = 0;
        if (!ce) return;
        mg = longint'(a);
        if (mg < 0) mg = -mg;
        if (mg > 64'sd2147483647) mg = 64'sd2147483647;
        hit = mg > longint'(energy_threshold);
        if (!m_lock) begin
            if (hit) begin
                m_hits++;
                if (m_hits == 8) begin
                    m_lock = 1; m_miss = 0;
                    qa.delete(); qs.delete();
                end
            end else begin
                m_hits = 0;
            end
        end else begin
            qa.push_back(a);
            qs.push_back(s);
            m_miss = hit ? 0 : m_miss + 1;
            if (m_miss == 4) begin
                m_lock = 0; m_hits = 0;
                qa.delete(); qs.delete();
            end else if (qa.size() == 16) begin
                m_soft = msum(qa);
                m_ferr = msum(qs);
                m_bit  = m_soft[ACC_W-1];
                m_bv   = 1;
                qa.delete(); qs.delete();
            end
        end
    endtask

    task automatic check_outputs();
        chk("carrier_lock", carrier_lock, m_lock);
        chk("bit_valid", bit_valid, m_bv);
        chk("bit_out", bit_out, m_bit);
        chk("soft_out", soft_out, m_soft);
        chk("freq_err", freq_err, m_ferr);
        if (bit_valid) bv_seen++;
    endtask

    // Apply one clock cycle of input, random filler in the unused low bits.
    task automatic drive(input int a, input int s, input bit ce);
        addition_in    = {a, $urandom(), $urandom(), $urandom()};
        subtraction_in = {s, $urandom(), $urandom()};
        clk_enable     = ce;
        #1;
        chk("ce_out", ce_out, ce);
        model_step(a, s, ce);
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs();
        @(posedge clk);
        @(posedge clk);
        #2;
        reset = 1'b0;
        #1;
        check_outputs();
    endtask

    initial begin
        int guard;
        int bv0;
        reset            = 1'b1;
        clk_enable       = 1'b0;
        addition_in      = '0;
        subtraction_in   = '0;
        energy_threshold = 32'd500;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs();
        do_reset();

        // Steady +1000: lock after 8 samples, one symbol after 16 more.
        for (int i = 0; i < 8; i++) drive(1000, 0, 1);
        chk("lock_after_8", carrier_lock, 1'b1);
        for (int i = 0; i < 16; i++) drive(1000, 0, 1);
        chk("pos_bv", bit_valid, 1'b1);
        chk("pos_bit", bit_out, 1'b0);
        chk("pos_soft", soft_out, 64'sd16000);
        chk("pos_ferr", freq_err, 64'sd0);
        drive(1000, 0, 1);
        chk("pos_bv_1cyc", bit_valid, 1'b0);

        // Reset in the middle of a symbol.
        for (int i = 0; i < 5; i++) drive(1000, 0, 1);
        do_reset();
        chk("rst_soft", soft_out, 64'sd0);
        for (int i = 0; i < 7; i++) drive(1000, 0, 1);
        chk("rst_no_lock7", carrier_lock, 1'b0);

        // Negative carrier, sparse sample strobe.
        do_reset();
        for (int i = 0; i < 3 * 40; i++) begin
            drive(-1000, 50, (i % 3) == 0);
            if (bit_valid) begin
                chk("neg_bit", bit_out, 1'b1);
                chk("neg_soft", soft_out, -64'sd16000);
                chk("neg_ferr", freq_err, 64'sd800);
            end
        end
        chk("neg_lock", carrier_lock, 1'b1);

        // Four misses starting at sample 10 of a symbol.
        guard = 0;
        while (qa.size() != 9 && guard < 64) begin
            drive(1000, 0, 1); guard++;
        end
        bv0 = bv_seen;
        for (int i = 0; i < 4; i++) drive(0, 0, 1);
        chk("miss10_unlock", carrier_lock, 1'b0);
        chk("miss10_no_bv", bv_seen, bv0);

        // Fourth miss lands on the dump sample.
        for (int i = 0; i < 8; i++) drive(1000, 0, 1);
        for (int i = 0; i < 12; i++) drive(1000, 0, 1);
        bv0 = bv_seen;
        for (int i = 0; i < 4; i++) drive(0, 0, 1);
        chk("miss16_unlock", carrier_lock, 1'b0);
        chk("miss16_no_bv", bv_seen, bv0);
        drive(0, 0, 1);

        // Full-scale positive input overflows a 34-bit accumulator.
        do_reset();
        for (int i = 0; i < 24; i++) drive(32'h7FFFFFFF, 0, 1);
        chk("ovf_bv", bit_valid, 1'b1);
`ifdef DPA_SLICER_SATURATE_EN
        chk("ovf_soft", soft_out, (64'sd1 <<< 33) - 1);
        chk("ovf_bit", bit_out, 1'b0);
`else
        chk("ovf_soft", soft_out, -64'sd16);
        chk("ovf_bit", bit_out, 1'b1);
`endif

        // Alternating hit/miss never locks.
        do_reset();
        bv0 = bv_seen;
        for (int i = 0; i < 40; i++) drive((i % 2) ? 0 : 1000, 0, 1);
        chk("alt_no_lock", carrier_lock, 1'b0);
        chk("alt_no_bv", bv_seen, bv0);

        // Random traffic, including most-negative and full-range samples.
        do_reset();
        energy_threshold = $urandom_range(200, 2000);
        for (int i = 0; i < 600; i++) begin
            int r, a;
            r = $urandom_range(0, 11);
            if (r == 0)      a = 0;
            else if (r == 1) a = int'(32'h80000000);
            else if (r == 2) a = int'($urandom());
            else if (r == 3) a = int'($urandom_range(0, 400));
            else if (r < 8)  a = int'($urandom_range(600, 200000));
            else             a = -int'($urandom_range(600, 200000));
            drive(a, int'($urandom()), $urandom_range(0, 3) != 0);
            if (i == 300) do_reset();
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_err);
        $finish;
    end

endmodule
